// File: rtl/jpeg_byte_stuffer.sv
// JPEG entropy-segment byte serializer: buffers 32-bit packed words in a small FIFO
// and emits them LSB-byte first, inserting a 0x00 after every 0xFF data byte.
module jpeg_byte_stuffer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        data_in_valid,
    input  logic [31:0]                 data_in,
    output logic                        data_out_valid,
    output logic [7:0]                  data_out,
    input  logic                        data_out_ready,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EMIT, STUFF} state_t;

    state_t        state;
    logic [31:0]   word;   // shifts right one byte per emitted data byte
    logic [1:0]    idx;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   head;
    logic          push, pop, hs, advance, last;

    assign head    = mem[rd_ptr];
    assign hs      = data_out_valid & data_out_ready;
    assign push    = data_in_valid && (level != FULL);
    assign advance = hs && !(state == EMIT && data_out == 8'hFF);
    assign last    = (idx == 2'd3);
    assign pop     = (level != '0) && ((state == IDLE) || (advance && last));

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Full is judged on the pre-edge level; a simultaneous pop does not help.
            if (data_in_valid && level == FULL) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state          <= IDLE;
            word           <= '0;
            idx            <= '0;
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        word           <= head;
                        idx            <= '0;
                        data_out       <= head[7:0];
                        data_out_valid <= 1'b1;
                        state          <= EMIT;
                    end
                end
                default: begin
                    if (hs) begin
                        if (!advance) begin
                            state    <= STUFF;
                            data_out <= 8'h00;
                        end else if (!last) begin
                            idx      <= idx + 2'd1;
                            word     <= {8'h00, word[31:8]};
                            data_out <= word[15:8];
                            state    <= EMIT;
                        end else if (pop) begin
                            // Back-to-back words: no bubble between byte 3 and next byte 0.
                            word     <= head;
                            idx      <= '0;
                            data_out <= head[7:0];
                            state    <= EMIT;
                        end else begin
                            data_out       <= 8'h00;
                            data_out_valid <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule
